fsm_input_arbiter: RTL and testbench
====================================

# fsm_input_arbiter

Round-robin arbiter that shares the single 8-bit input port of the `tt_um_fsm` state machine between several requesters. It grants one requester at a time and captures its byte. It drives the byte into the FSM with a one-cycle load strobe, then holds the grant until the FSM reports completion or a timeout expires. It sits between the requester logic and the FSM's `ui_in` path inside the tile.

## Interface
Parameters:
- `NREQ`, 4, number of requesters (2..8)
- `DW`, 8, data width of each request and of `fsm_in`
- `TIMEOUT`, 255, maximum WAIT cycles before abort (1..255; counter is 8 bits)

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge
- `rst`  in  1  reset; synchronous and active-high
- `req_valid`  in  NREQ  request pending, one bit per requester
- `req_data`  in  NREQ*DW  request bytes; requester i uses bits [i*DW +: DW]
- `req_ready`  out  NREQ  one-hot acceptance strobe
- `fsm_in`  out  DW  registered byte driven to the FSM input
- `fsm_load`  out  1  one-cycle strobe; `fsm_in` is valid
- `fsm_done`  in  1  FSM finished processing the current byte
- `grant_id`  out  $clog2(NREQ)  index of the current or last granted requester
- `busy`  out  1  high in every state except IDLE
- `timeout_err`  out  1  one-cycle pulse on abort

## Operation
- States: IDLE, LOAD, WAIT, RELEASE.
- **IDLE**
  - If any `req_valid` is high, select the first requester at or after `ptr`, searching upward with wrap.
  - Assert `req_ready[sel]` combinationally in the same cycle.
  - Register `req_data[sel]` into `fsm_in` and `sel` into `grant_id`.
  - Go to LOAD.
  - If no request is pending, stay in IDLE with `req_ready` = 0.
- **LOAD**
  - `fsm_load` = 1 for exactly this cycle.
  - Clear the wait counter.
  - Go to WAIT.
- **WAIT**
  - On `fsm_done`, go to RELEASE.
  - Otherwise increment the counter. When the counter equals `TIMEOUT`, pulse `timeout_err` and go to RELEASE.
  - If `fsm_done` and the timeout coincide, `fsm_done` wins and `timeout_err` stays 0.
- **RELEASE**
  - `ptr` <= `grant_id` + 1, wrapping to 0 at `NREQ`.
  - Go to IDLE.
- Handshake rules:
  - A requester holds `req_valid` and its data stable until it sees `req_ready`.
  - `req_valid` that drops before acceptance is ignored with no error.
- `fsm_done` outside WAIT is ignored.
- `fsm_in` and `grant_id` hold their value until the next acceptance.
- Reset values: state IDLE, `ptr` = 0, `fsm_in` = 0, `grant_id` = 0, `fsm_load` = 0, `busy` = 0, `timeout_err` = 0, counter = 0.
- Reset asserted mid-transaction aborts the transaction. No `req_ready`, `fsm_load` or `timeout_err` is emitted in the reset cycle.

## Timing
- Acceptance to load: `req_ready` in cycle N, `fsm_load` in N+1, WAIT from N+2.
- Minimum grant period: `fsm_done` in N+2 gives RELEASE in N+3 and IDLE in N+4. The next `req_ready` can appear in N+4.
- Timeout: `timeout_err` pulses in the cycle the counter reaches `TIMEOUT`, which is `TIMEOUT` WAIT cycles after entering WAIT.
- Fairness: a requester that stays continuously valid is granted within `NREQ` grants.
- Outputs `fsm_in`, `fsm_load`, `grant_id`, `busy` and `timeout_err` are registered. Only `req_ready` is combinational from `req_valid`.

## Configuration
- Macro: `FSM_ARB_TIMEOUT_EN`.
- Defined: the wait counter and timeout abort are present, as described above.
- Undefined:
  - No counter is synthesized.
  - `timeout_err` is tied to 0.
  - WAIT exits only on `fsm_done` and can stall indefinitely.
  - The `TIMEOUT` parameter is ignored.

## Structure
- Package `fsm_arb_pkg`:
  - State enum typedef `arb_state_t` (IDLE, LOAD, WAIT, RELEASE).
  - Default constants `ARB_NREQ`, `ARB_DW`, `ARB_TIMEOUT`.
- Sub-module `rr_pick`: combinational round-robin picker.
  - Inputs: `req` and `ptr`.
  - Outputs: `any` and `idx`.
  - Implemented as a doubled request vector with a priority encoder.

## Test plan
- **Single request, fast done**
  - Stimulus: after reset, `req_valid` = 4'b0010, data 0xA5; `fsm_done` pulsed 1 cycle after `fsm_load`.
  - Response: `req_ready` = 4'b0010 in the first cycle; `fsm_load` = 1 next cycle with `fsm_in` = 0xA5 and `grant_id` = 1; `busy` drops 4 cycles after acceptance.
- **All four requesting continuously**
  - Grant order is 0,1,2,3,0 and no requester is granted twice before the others.
- **Timeout (macro defined, `TIMEOUT` = 5)**
  - Stimulus: `fsm_done` never asserted.
  - Response: `timeout_err` pulses once, 5 cycles into WAIT, then returns to IDLE; the next grant goes to the next index.
- **Done and timeout in the same cycle**
  - Response: `timeout_err` stays 0 and the transaction completes normally.
- **Reset mid-WAIT**
  - Stimulus: `rst` = 1 for 1 cycle while in WAIT.
  - Response: all outputs return to 0; the next acceptance, with requesters 0 and 2 valid, goes to requester 0.
- **Stray done**
  - Stimulus: `fsm_done` pulsed in IDLE and in LOAD.
  - Response: no state change, and WAIT still waits for a later `fsm_done`.

Source files
------------

// File: rtl/fsm_arb_pkg.sv
// rtl/fsm_arb_pkg.sv - shared state type and default sizes for the FSM input arbiter
package fsm_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_t;

    localparam int ARB_NREQ    = 4;
    localparam int ARB_DW      = 8;
    localparam int ARB_TIMEOUT = 255;

endpackage

// File: rtl/fsm_input_arbiter_rr_pick.sv
// rtl/fsm_input_arbiter_rr_pick.sv - combinational round-robin picker (doubled vector + priority encoder)
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic            any,
    output logic [IW-1:0]   idx
);

    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    int                sum;

    // Rotating the doubled vector puts the requester at ptr in bit 0, so the lowest set bit wins.
    always_comb begin
        dbl = {req, req};
        rot = NREQ'(dbl >> ptr);
        any = |req;
        idx = '0;
        sum = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                sum = int'(ptr) + k;
                if (sum >= NREQ) sum = sum - NREQ;
                idx = IW'(sum);
            end
        end
    end

endmodule

// File: rtl/fsm_input_arbiter.sv
// rtl/fsm_input_arbiter.sv - round-robin arbiter feeding the FSM input byte; FSM_ARB_TIMEOUT_EN enables the WAIT timeout
module fsm_input_arbiter
    import fsm_arb_pkg::*;
#(
    parameter int NREQ    = ARB_NREQ,
    parameter int DW      = ARB_DW,
    parameter int TIMEOUT = ARB_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*DW-1:0]       req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic [DW-1:0]            fsm_in,
    output logic                     fsm_load,
    input  logic                     fsm_done,
    output logic [$clog2(NREQ)-1:0]  grant_id,
    output logic                     busy,
    output logic                     timeout_err
);

    localparam int IW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_cfg
        $error("fsm_input_arbiter: NREQ must be 2..8 and TIMEOUT 1..255");
    end

    arb_state_t     state;
    logic [IW-1:0]  ptr;
    logic           any;
    logic [IW-1:0]  sel;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req (req_valid),
        .ptr (ptr),
        .any (any),
        .idx (sel)
    );

    // Acceptance is combinational so the requester can drop valid on the next edge.
    always_comb begin
        req_ready = '0;
        if (!rst && state == ST_IDLE && any) req_ready[sel] = 1'b1;
    end

`ifdef FSM_ARB_TIMEOUT_EN
    logic [7:0] cnt;
    logic       to_pulse;

    assign timeout_err = to_pulse;
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            fsm_in   <= '0;
            grant_id <= '0;
            fsm_load <= 1'b0;
            busy     <= 1'b0;
`ifdef FSM_ARB_TIMEOUT_EN
            cnt      <= '0;
            to_pulse <= 1'b0;
`endif
        end else begin
            fsm_load <= 1'b0;
`ifdef FSM_ARB_TIMEOUT_EN
            to_pulse <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (any) begin
                        fsm_in   <= req_data[int'(sel)*DW +: DW];
                        grant_id <= sel;
                        fsm_load <= 1'b1;
                        busy     <= 1'b1;
                        state    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
`ifdef FSM_ARB_TIMEOUT_EN
                    cnt   <= '0;
`endif
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Done is tested first so it beats a coinciding timeout.
                    if (fsm_done) begin
                        state <= ST_RELEASE;
                    end
`ifdef FSM_ARB_TIMEOUT_EN
                    else begin
                        cnt <= cnt + 8'd1;
                        if (cnt + 8'd1 == 8'(TIMEOUT)) begin
                            to_pulse <= 1'b1;
                            state    <= ST_RELEASE;
                        end
                    end
`endif
                end
                ST_RELEASE: begin
                    ptr   <= (grant_id == IW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fsm_input_arbiter.sv
// tb/tb_fsm_input_arbiter.sv - directed self-checking bench for fsm_input_arbiter (NREQ=4, DW=8, TIMEOUT=5)
module tb_fsm_input_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic [7:0]  fsm_in;
    logic        fsm_load;
    logic        fsm_done;
    logic [1:0]  grant_id;
    logic        busy;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    fsm_input_arbiter #(.NREQ(4), .DW(8), .TIMEOUT(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .fsm_in      (fsm_in),
        .fsm_load    (fsm_load),
        .fsm_done    (fsm_done),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(negedge clk);
    endtask

    // From a negedge where LOAD is visible: one WAIT cycle, done, back in IDLE.
    task automatic finish_txn;
        step;
        fsm_done = 1'b1;
        step;
        fsm_done = 1'b0;
        step;
    endtask

    task automatic test_reset;
        rst = 1'b1; req_valid = 4'b1111; req_data = 32'h44332211; fsm_done = 1'b0;
        step;
        step;
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++; $display("FAIL reset_ready got %b want 0000", req_ready);
        end
        checks++;
        if ({fsm_load, busy, timeout_err, grant_id, fsm_in} !== 13'h0) begin
            errors++; $display("FAIL reset_outputs got load=%b busy=%b to=%b gid=%0d in=%h want all 0",
                                fsm_load, busy, timeout_err, grant_id, fsm_in);
        end
        rst = 1'b0; req_valid = 4'b0000;
    endtask

    task automatic test_single;
        step;
        req_valid = 4'b0010; req_data[15:8] = 8'hA5;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++; $display("FAIL single_ready got %b want 0010", req_ready);
        end
        step;
        req_valid = 4'b0000;
        checks++;
        if ({fsm_load, fsm_in, grant_id, busy} !== {1'b1, 8'hA5, 2'd1, 1'b1}) begin
            errors++; $display("FAIL single_load got load=%b in=%h gid=%0d busy=%b want 1 a5 1 1",
                                fsm_load, fsm_in, grant_id, busy);
        end
        step;
        checks++;
        if ({fsm_load, busy} !== 2'b01) begin
            errors++; $display("FAIL single_wait got load=%b busy=%b want 0 1", fsm_load, busy);
        end
        fsm_done = 1'b1;
        step;
        fsm_done = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL single_release_busy got %b want 1", busy);
        end
        step;
        checks++;
        if ({busy, grant_id, fsm_in} !== {1'b0, 2'd1, 8'hA5}) begin
            errors++; $display("FAIL single_idle got busy=%b gid=%0d in=%h want 0 1 a5", busy, grant_id, fsm_in);
        end
    endtask

    task automatic test_round_robin;
        rst = 1'b1;
        step;
        rst = 1'b0;
        req_data = 32'h13121110;
        req_valid = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            #1;
            checks++;
            if (req_ready !== 4'(1 << (g % 4))) begin
                errors++; $display("FAIL rr_ready grant %0d got %b want %b", g, req_ready, 4'(1 << (g % 4)));
            end
            step;
            checks++;
            if ({fsm_load, grant_id, fsm_in} !== {1'b1, 2'(g % 4), 8'(8'h10 + g % 4)}) begin
                errors++; $display("FAIL rr_load grant %0d got load=%b gid=%0d in=%h want 1 %0d %h",
                                    g, fsm_load, grant_id, fsm_in, g % 4, 8'h10 + g % 4);
            end
            finish_txn;
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_timeout;
        req_valid = 4'b1000; req_data[31:24] = 8'hC3;
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin
            errors++; $display("FAIL to_ready got %b want 1000", req_ready);
        end
        step;
        req_valid = 4'b0000;
        checks++;
        if ({fsm_load, grant_id} !== {1'b1, 2'd3}) begin
            errors++; $display("FAIL to_load got load=%b gid=%0d want 1 3", fsm_load, grant_id);
        end
`ifdef FSM_ARB_TIMEOUT_EN
        for (int i = 0; i < 5; i++) begin
            step;
            checks++;
            if ({timeout_err, busy} !== 2'b01) begin
                errors++; $display("FAIL to_wait cycle %0d got to=%b busy=%b want 0 1", i, timeout_err, busy);
            end
        end
        step;
        checks++;
        if ({timeout_err, busy} !== 2'b11) begin
            errors++; $display("FAIL to_pulse got to=%b busy=%b want 1 1", timeout_err, busy);
        end
        step;
        checks++;
        if ({timeout_err, busy} !== 2'b00) begin
            errors++; $display("FAIL to_after got to=%b busy=%b want 0 0", timeout_err, busy);
        end
`else
        for (int i = 0; i < 20; i++) begin
            step;
            checks++;
            if ({timeout_err, busy} !== 2'b01) begin
                errors++; $display("FAIL stall_wait cycle %0d got to=%b busy=%b want 0 1", i, timeout_err, busy);
            end
        end
        fsm_done = 1'b1;
        step;
        fsm_done = 1'b0;
        step;
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL stall_release got busy=%b want 0", busy);
        end
`endif
        req_valid = 4'b1001; req_data[7:0] = 8'h01;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++; $display("FAIL to_next_ready got %b want 0001", req_ready);
        end
        step;
        req_valid = 4'b0000;
        finish_txn;
    endtask

    task automatic test_done_timeout;
        req_valid = 4'b0100; req_data[23:16] = 8'h5A;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++; $display("FAIL dt_ready got %b want 0100", req_ready);
        end
        step;
        req_valid = 4'b0000;
        for (int i = 0; i < 5; i++) step;
        fsm_done = 1'b1;
        step;
        fsm_done = 1'b0;
        checks++;
        if ({timeout_err, busy} !== 2'b01) begin
            errors++; $display("FAIL dt_release got to=%b busy=%b want 0 1", timeout_err, busy);
        end
        step;
        checks++;
        if ({timeout_err, busy, grant_id, fsm_in} !== {1'b0, 1'b0, 2'd2, 8'h5A}) begin
            errors++; $display("FAIL dt_idle got to=%b busy=%b gid=%0d in=%h want 0 0 2 5a",
                                timeout_err, busy, grant_id, fsm_in);
        end
    endtask

    task automatic test_reset_mid_wait;
        req_valid = 4'b0010; req_data = 32'h44332211;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++; $display("FAIL rmw_ready got %b want 0010", req_ready);
        end
        step;
        req_valid = 4'b0000;
        step;
        rst = 1'b1; req_valid = 4'b0101;
        step;
        #1;
        checks++;
        if ({req_ready, fsm_load, busy, timeout_err, grant_id, fsm_in} !== 17'h0) begin
            errors++; $display("FAIL rmw_reset got ready=%b load=%b busy=%b to=%b gid=%0d in=%h want all 0",
                                req_ready, fsm_load, busy, timeout_err, grant_id, fsm_in);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++; $display("FAIL rmw_next_ready got %b want 0001", req_ready);
        end
        step;
        req_valid = 4'b0000;
        checks++;
        if ({fsm_load, grant_id, fsm_in} !== {1'b1, 2'd0, 8'h11}) begin
            errors++; $display("FAIL rmw_next_load got load=%b gid=%0d in=%h want 1 0 11", fsm_load, grant_id, fsm_in);
        end
        finish_txn;
    endtask

    task automatic test_stray_done;
        fsm_done = 1'b1;
        step;
        checks++;
        if ({fsm_load, busy} !== 2'b00) begin
            errors++; $display("FAIL stray_idle got load=%b busy=%b want 0 0", fsm_load, busy);
        end
        req_valid = 4'b0100;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++; $display("FAIL stray_ready got %b want 0100", req_ready);
        end
        step;
        req_valid = 4'b0000;
        checks++;
        if (fsm_load !== 1'b1) begin
            errors++; $display("FAIL stray_load got %b want 1", fsm_load);
        end
        step;
        fsm_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({fsm_load, busy} !== 2'b01) begin
                errors++; $display("FAIL stray_wait cycle %0d got load=%b busy=%b want 0 1", i, fsm_load, busy);
            end
            step;
        end
        fsm_done = 1'b1;
        step;
        fsm_done = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL stray_release got busy=%b want 1", busy);
        end
        step;
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL stray_done_idle got busy=%b want 0", busy);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_single;
        test_round_robin;
        test_timeout;
        test_done_timeout;
        test_reset_mid_wait;
        test_stray_done;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
